// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared qualifier-mode constants and FSM state encoding for bus_sync_hs
package sync_pkg;

  localparam int EN_MODE_PULSE  = 0;
  localparam int EN_MODE_TOGGLE = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sync_state_e;

endpackage : sync_pkg

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - reset-to-0 single-bit synchroniser flop chain
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  // cdc: synchroniser chain 'chain', STAGES flops deep, i_d is asynchronous to i_clk
  logic [STAGES-1:0] chain;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = chain[STAGES-1];

endmodule : bit_sync

// File: rtl/bus_sync_hs.sv
// rtl/bus_sync_hs.sv - MCP bus synchroniser destination half with valid/ready, ack toggle and overrun
`ifndef WIDTH
`define WIDTH 8
`endif

module bus_sync_hs
  import sync_pkg::*;
#(
  parameter int WIDTH       = `WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int EN_MODE     = EN_MODE_PULSE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_async_en,
  input  logic [WIDTH-1:0] i_async_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sync_data,
  output logic             o_sync_valid,
  output logic             o_ack,
  output logic             o_overrun
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("bus_sync_hs: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic        en_sync;
  logic        en_d;
  logic        en_event;
  logic        capture;
  logic        drop;
  sync_state_e state_q;
  sync_state_e state_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_en_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_async_en),
    .o_q   (en_sync)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      en_d <= 1'b0;
    end else begin
      en_d <= en_sync;
    end
  end

  assign en_event = (EN_MODE == EN_MODE_TOGGLE) ? (en_sync ^ en_d) : (en_sync & ~en_d);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (en_event) begin
          capture = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // a consume and a new capture can share one edge, so only a blocked event is lost
        if (en_event) begin
          if (i_ready) begin
            capture = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (i_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_EMPTY;
      o_sync_data <= '0;
      o_ack       <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_overrun <= drop;
      if (capture) begin
        o_sync_data <= i_async_data;
        o_ack       <= ~o_ack;
      end
    end
  end

  assign o_sync_valid = (state_q == ST_FULL);

endmodule : bus_sync_hs

// File: tb/tb_bus_sync_hs.sv
// tb/tb_bus_sync_hs.sv - directed self-checking bench for bus_sync_hs
module tb_bus_sync_hs;

  logic       clk;
  logic       rst;

  logic       en_p;
  logic [7:0] data_p;
  logic       ready_p;
  logic [7:0] a_data;
  logic       a_valid, a_ack, a_ov;
  logic [7:0] b_data;
  logic       b_valid, b_ack, b_ov;

  logic       en_t;
  logic [7:0] data_t;
  logic       ready_t;
  logic [7:0] t_data;
  logic       t_valid, t_ack, t_ov;

  int checks = 0;
  int errors = 0;
  logic t_ov_seen = 1'b0;
  int valid_cnt;

  bus_sync_hs #(.WIDTH(8), .SYNC_STAGES(2), .EN_MODE(0)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_async_en(en_p), .i_async_data(data_p), .i_ready(ready_p),
    .o_sync_data(a_data), .o_sync_valid(a_valid), .o_ack(a_ack), .o_overrun(a_ov)
  );

  bus_sync_hs #(.WIDTH(8), .SYNC_STAGES(4), .EN_MODE(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_async_en(en_p), .i_async_data(data_p), .i_ready(ready_p),
    .o_sync_data(b_data), .o_sync_valid(b_valid), .o_ack(b_ack), .o_overrun(b_ov)
  );

  bus_sync_hs #(.WIDTH(8), .SYNC_STAGES(2), .EN_MODE(1)) u_dut_t (
    .i_clk(clk), .i_rst(rst), .i_async_en(en_t), .i_async_data(data_t), .i_ready(ready_t),
    .o_sync_data(t_data), .o_sync_valid(t_valid), .o_ack(t_ack), .o_overrun(t_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t_ov_seen = t_ov_seen | t_ov;
    end
  endtask

  initial begin
    rst = 1'b0; en_p = 1'b0; data_p = 8'h00; ready_p = 1'b1;
    en_t = 1'b0; data_t = 8'h00; ready_t = 1'b1;
    tick(3);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_a_ov", a_ov, 0);
    check("rst_b_valid", b_valid, 0);
    rst = 1'b1;
    tick(2);

    // basic transfer: enable driven just after edge 0
    data_p = 8'hA5;
    tick();
    en_p = 1'b1;
    tick(); check("e1_a_valid", a_valid, 0); check("e1_b_valid", b_valid, 0);
    tick(); check("e2_a_valid", a_valid, 0); check("e2_b_valid", b_valid, 0);
    tick();
    check("e3_a_valid", a_valid, 1);
    check("e3_a_data", a_data, 8'hA5);
    check("e3_a_ack", a_ack, 1);
    check("e3_b_valid", b_valid, 0);
    check("e3_b_ack", b_ack, 0);
    tick();
    check("e4_a_valid", a_valid, 0);
    check("e4_a_data", a_data, 8'hA5);
    check("e4_b_valid", b_valid, 0);
    tick();
    check("e5_b_valid", b_valid, 1);
    check("e5_b_data", b_data, 8'hA5);
    check("e5_b_ack", b_ack, 1);
    tick();
    check("e6_b_valid", b_valid, 0);
    en_p = 1'b0;
    tick(6);

    // back-pressure and overrun
    ready_p = 1'b0; data_p = 8'h11; en_p = 1'b1;
    tick(3);
    check("bp_valid", a_valid, 1);
    check("bp_data", a_data, 8'h11);
    check("bp_ack", a_ack, 0);
    en_p = 1'b0;
    tick(4);
    data_p = 8'h22; en_p = 1'b1;
    tick(2);
    check("ov_pre", a_ov, 0);
    tick();
    check("ov_pulse", a_ov, 1);
    check("ov_data", a_data, 8'h11);
    check("ov_ack", a_ack, 0);
    check("ov_valid", a_valid, 1);
    tick();
    check("ov_clear", a_ov, 0);
    ready_p = 1'b1;
    tick();
    check("bp_drain", a_valid, 0);
    check("bp_drain_data", a_data, 8'h11);
    en_p = 1'b0;
    tick(5);

    // consume and capture on the same edge
    ready_p = 1'b0; data_p = 8'h11; en_p = 1'b1;
    tick(3);
    check("sim_full", a_valid, 1);
    check("sim_ack0", a_ack, 1);
    en_p = 1'b0;
    tick(4);
    check("sim_hold", a_valid, 1);
    data_p = 8'h33; en_p = 1'b1;
    tick(2);
    ready_p = 1'b1;
    tick();
    check("sim_valid", a_valid, 1);
    check("sim_data", a_data, 8'h33);
    check("sim_ack", a_ack, 0);
    check("sim_ov", a_ov, 0);
    tick();
    check("sim_drain", a_valid, 0);
    en_p = 1'b0;
    tick(5);

    // toggle mode: three level changes, three captures
    data_t = 8'h01; en_t = 1'b1;
    tick(3);
    check("tg1_valid", t_valid, 1); check("tg1_data", t_data, 8'h01); check("tg1_ack", t_ack, 1);
    tick();
    check("tg1_drain", t_valid, 0);
    data_t = 8'h02; en_t = 1'b0;
    tick(3);
    check("tg2_valid", t_valid, 1); check("tg2_data", t_data, 8'h02); check("tg2_ack", t_ack, 0);
    tick();
    data_t = 8'h03; en_t = 1'b1;
    tick(3);
    check("tg3_valid", t_valid, 1); check("tg3_data", t_data, 8'h03); check("tg3_ack", t_ack, 1);
    tick();
    check("tg3_drain", t_valid, 0);
    check("tg_no_ov", t_ov_seen, 0);

    // asynchronous reset while holding a word
    ready_p = 1'b0; data_p = 8'hFF; en_p = 1'b1;
    tick(3);
    check("rs_full", a_valid, 1);
    check("rs_data", a_data, 8'hFF);
    check("rs_ack", a_ack, 1);
    #2 rst = 1'b0;
    #1;
    check("rs_async_valid", a_valid, 0);
    check("rs_async_data", a_data, 0);
    check("rs_async_ack", a_ack, 0);
    check("rs_async_ov", a_ov, 0);
    ready_p = 1'b1;
    tick();
    rst = 1'b1;
    valid_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_valid) valid_cnt++;
    end
    check("rs_one_capture", valid_cnt, 1);
    check("rs_cap_data", a_data, 8'hFF);
    check("rs_cap_ack", a_ack, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_sync_hs
